// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped read-only instruction cache with a single outstanding tagged miss
module icache_ctrl #(
    parameter int CACHE_LINES = 32,
    parameter int MEM_TAG_W   = 4,
    parameter int XLEN        = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [XLEN-1:0]      proc2Icache_addr,
    input  logic                 icache_flush,
    output logic [63:0]          Icache2proc_data,
    output logic                 Icache2proc_data_valid,
    output logic [1:0]           proc2mem_command,
    output logic [XLEN-1:0]      proc2mem_addr,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag,
    output logic [31:0]          miss_count_debug
);

    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = XLEN - IDX_W - 3;
    localparam int LINE_W = XLEN - 3;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [LINE_W-1:0]      miss_line_q, miss_line_d;
    logic [MEM_TAG_W-1:0]   mem_tag_q, mem_tag_d;
    logic                   drop_fill_q, drop_fill_d;
    logic [31:0]            miss_count_q, miss_count_d;
    logic [CACHE_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tags_q [CACHE_LINES];
    logic [63:0]            data_q [CACHE_LINES];

    logic [IDX_W-1:0]       cur_idx, miss_idx;
    logic [TAG_W-1:0]       cur_tag, miss_tag;
    logic                   hit;
    logic                   fill_we;
    logic                   unused_addr_bits;

    assign cur_idx  = proc2Icache_addr[IDX_W+2:3];
    assign cur_tag  = proc2Icache_addr[XLEN-1:IDX_W+3];
    assign miss_idx = miss_line_q[IDX_W-1:0];
    assign miss_tag = miss_line_q[LINE_W-1:IDX_W];
    assign hit      = valid_q[cur_idx] && (tags_q[cur_idx] == cur_tag);
    assign unused_addr_bits = ^proc2Icache_addr[2:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            miss_line_q  <= '0;
            mem_tag_q    <= '0;
            drop_fill_q  <= 1'b0;
            miss_count_q <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_line_q  <= miss_line_d;
            mem_tag_q    <= mem_tag_d;
            drop_fill_q  <= drop_fill_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
        end
    end

    // Line storage is not reset; only the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            tags_q[miss_idx] <= miss_tag;
            data_q[miss_idx] <= mem2proc_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_line_d  = miss_line_q;
        mem_tag_d    = mem_tag_q;
        drop_fill_d  = drop_fill_q;
        miss_count_d = miss_count_q;
        fill_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit && !icache_flush) begin
                    miss_line_d = proc2Icache_addr[XLEN-1:3];
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // An accepted LOAD must be tracked even under flush so its return is discarded.
                if (mem2proc_response != '0) begin
                    mem_tag_d   = mem2proc_response;
                    drop_fill_d = icache_flush;
                    state_d     = S_WAIT;
                    if (miss_count_q != 32'hFFFF_FFFF) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                end else if (icache_flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem2proc_tag != '0 && mem2proc_tag == mem_tag_q) begin
                    fill_we     = !drop_fill_q && !icache_flush;
                    drop_fill_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (icache_flush) begin
                    drop_fill_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = valid_q;
        if (fill_we) begin
            valid_d[miss_idx] = 1'b1;
        end
        if (icache_flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        Icache2proc_data_valid = hit;
        Icache2proc_data       = hit ? data_q[cur_idx] : 64'h0;
        proc2mem_command       = BUS_NONE;
        proc2mem_addr          = '0;
        if (state_q == S_REQ) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = {miss_line_q, 3'b000};
        end
    end

    assign miss_count_debug = miss_count_q;

endmodule
